// File: rtl/matrix_scan_driver.sv
// ============================================================================
// Module   : matrix_scan_driver
// Brief    : Column-multiplexed 8x8 LED matrix driver with per-frame bitmap
//            latch, per-column dwell and blanking gap. Optional PWM row
//            dimming when MATRIX_BRIGHTNESS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_scan_driver #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] info,
`ifdef MATRIX_BRIGHTNESS_EN
  input  logic [3:0]  brightness,
`endif
  input  logic        en,
  output logic [7:0]  col_sel,
  output logic [7:0]  row_data,
  output logic [2:0]  scan_idx,
  output logic        frame_start
);

  localparam int c_max_cnt = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int c_cnt_w   = (c_max_cnt > 2) ? $clog2(c_max_cnt) : 1;
  localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  localparam logic [1:0] c_load  = 2'd0;
  localparam logic [1:0] c_drive = 2'd1;
  localparam logic [1:0] c_blank = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2:0]         col_idx_q, col_idx_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [63:0]        frame_q, frame_d;
  logic [7:0]         col_sel_q, col_sel_d;
  logic [7:0]         pat_q, pat_d;
  logic [2:0]         scan_idx_q, scan_idx_d;
  logic               frame_start_q, frame_start_d;
  logic [2:0]         next_col;
  logic               advance;

  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    cnt_d         = cnt_q;
    frame_d       = frame_q;
    col_sel_d     = col_sel_q;
    pat_d         = pat_q;
    scan_idx_d    = scan_idx_q;
    frame_start_d = 1'b0;
    next_col      = col_idx_q + 3'd1;
    advance       = 1'b0;

    if (!en) begin
      // Abandon any partial frame; the next enable takes a fresh latch.
      state_d   = c_load;
      col_idx_d = 3'd0;
      cnt_d     = '0;
      col_sel_d = 8'h00;
      pat_d     = 8'h00;
    end else begin
      case (state_q)
        c_load: begin
          frame_d       = info;
          frame_start_d = 1'b1;
          col_idx_d     = 3'd0;
          scan_idx_d    = 3'd0;
          col_sel_d     = 8'h01;
          pat_d         = info[7:0];
          cnt_d         = '0;
          state_d       = c_drive;
        end
        c_drive: begin
          if (cnt_q == c_dwell_last) begin
            if (BLANK_CYCLES > 0) begin
              state_d   = c_blank;
              cnt_d     = '0;
              col_sel_d = 8'h00;
              pat_d     = 8'h00;
            end else begin
              advance = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        c_blank: begin
          if (cnt_q == c_blank_last) begin
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = c_load;
      endcase
    end

    if (advance) begin
      cnt_d = '0;
      if (col_idx_q != 3'd7) begin
        col_idx_d  = next_col;
        col_sel_d  = 8'h01 << next_col;
        pat_d      = frame_q[{next_col, 3'b000} +: 8];
        scan_idx_d = next_col;
        state_d    = c_drive;
      end else begin
        state_d   = c_load;
        col_sel_d = 8'h00;
        pat_d     = 8'h00;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= c_load;
      col_idx_q     <= 3'd0;
      cnt_q         <= '0;
      frame_q       <= 64'd0;
      col_sel_q     <= 8'h00;
      pat_q         <= 8'h00;
      scan_idx_q    <= 3'd0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      col_sel_q     <= col_sel_d;
      pat_q         <= pat_d;
      scan_idx_q    <= scan_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef MATRIX_BRIGHTNESS_EN
  logic [3:0] pwm_q, pwm_d;
  logic [7:0] row_gate_q, row_gate_d;

  // Every DRIVE entry zeroes the dwell counter, so cnt_d==0 marks an entry.
  always_comb begin
    pwm_d      = 4'd0;
    if ((state_d == c_drive) && (cnt_d != '0)) begin
      pwm_d = pwm_q + 4'd1;
    end
    row_gate_d = (pwm_d <= brightness) ? pat_d : 8'h00;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_q      <= 4'd0;
      row_gate_q <= 8'h00;
    end else begin
      pwm_q      <= pwm_d;
      row_gate_q <= row_gate_d;
    end
  end

  assign row_data = row_gate_q;
`else
  assign row_data = pat_q;
`endif

  assign col_sel     = col_sel_q;
  assign scan_idx    = scan_idx_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
// ============================================================================
// Module   : tb_matrix_scan_driver
// Brief    : Self-checking bench for matrix_scan_driver (DWELL=4, BLANK=2)
//            against a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_scan_driver;

  localparam int D = 4;
  localparam int B = 2;
  localparam int P = 1 + 8 * (D + B);

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        en = 1'b0;
  logic [63:0] info = 64'd0;
  logic [7:0]  col_sel;
  logic [7:0]  row_data;
  logic [2:0]  scan_idx;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: position within the current frame since its latch edge.
  bit          m_active;
  int          m_t;
  logic [63:0] m_frame;
  logic [2:0]  m_scan;

  matrix_scan_driver #(
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .info(info),
    .en(en),
    .col_sel(col_sel),
    .row_data(row_data),
    .scan_idx(scan_idx),
    .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_frame  = 64'd0;
    m_scan   = 3'd0;
  endtask

  task automatic model_edge();
    if (!en) begin
      m_active = 1'b0;
    end else if (!m_active || m_t == P - 1) begin
      m_active = 1'b1;
      m_t      = 0;
      m_frame  = info;
    end else begin
      m_t++;
    end
    if (m_active && m_t < P - 1 && (m_t % (D + B)) < D) m_scan = 3'(m_t / (D + B));
  endtask

  task automatic check_outputs();
    logic [7:0] e_col, e_row;
    logic       e_fs;
    int         col;
    e_col = 8'h00;
    e_row = 8'h00;
    e_fs  = 1'b0;
    if (m_active && m_t < P - 1) begin
      col = m_t / (D + B);
      if ((m_t % (D + B)) < D) begin
        e_col = 8'(1 << col);
        e_row = m_frame[col*8 +: 8];
      end
      e_fs = (m_t == 0);
    end
    check_value("col_sel", col_sel, e_col);
    check_value("row_data", row_data, e_row);
    check_value("scan_idx", scan_idx, m_scan);
    check_value("frame_start", frame_start, e_fs);
    check_value("onehot", ($countones(col_sel) <= 1), 1);
    if (col_sel == 8'h00) check_value("blank_row", row_data, 8'h00);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic wait_phase(input int target);
    bit found = 1'b0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      step();
      if (m_active && m_t == target) found = 1'b1;
    end
    check_value("wait_phase", found, 1);
  endtask

  // Called just after an edge; asserts reset between edges.
  task automatic do_async_reset();
    #2 RST_N = 1'b0;
    #1;
    check_value("async_col_sel", col_sel, 8'h00);
    check_value("async_row_data", row_data, 8'h00);
    check_value("async_scan_idx", scan_idx, 3'd0);
    check_value("async_frame_start", frame_start, 1'b0);
    model_reset();
    info = {$urandom, $urandom};
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    int fs_first, fs_second, zeros;
    model_reset();
    #2;
    check_value("reset_col_sel", col_sel, 8'h00);
    check_value("reset_row_data", row_data, 8'h00);
    check_value("reset_scan_idx", scan_idx, 3'd0);
    check_value("reset_frame_start", frame_start, 1'b0);
    info = 64'h8040201008040201;
    en   = 1'b1;
    #10 RST_N = 1'b1;

    // Diagonal frame, then a mid-frame info change that must wait a frame.
    fs_first  = -1;
    fs_second = -1;
    zeros     = 0;
    for (int i = 0; i < 110; i++) begin
      if (i == 10) info = 64'h000000000000FFFF;
      step();
      if (i == 0) begin
        check_value("first_fs", frame_start, 1'b1);
        check_value("first_col", col_sel, 8'h01);
        check_value("first_row", row_data, 8'h01);
      end
      if (i < P && col_sel == 8'h00) zeros++;
      if (frame_start) begin
        if (fs_first < 0) fs_first = cyc;
        else if (fs_second < 0) fs_second = cyc;
      end
    end
    check_value("frame_period", fs_second - fs_first, P);
    check_value("zero_cycles", zeros, 1 + 8 * B);

    // Enable dropped mid-column-3 drive.
    wait_phase(3 * (D + B) + 1);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_value("en_low_col", col_sel, 8'h00);
    end
    info = 64'hA5A5_5A5A_0F0F_F0F0;
    en   = 1'b1;
    step();
    check_value("restart_fs", frame_start, 1'b1);
    check_value("restart_col", col_sel, 8'h01);
    check_value("restart_row", row_data, 8'hF0);

    // Reset asserted mid-blank of column 5, then during a drive.
    wait_phase(5 * (D + B) + D);
    do_async_reset();
    for (int i = 0; i < 3 * P / 2; i++) step();
    wait_phase(6 * (D + B) + 1);
    do_async_reset();

    // Randomized traffic: info churn, enable gaps and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) info = {$urandom, $urandom};
      if (en) begin
        if ($urandom_range(0, 79) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      step();
      if ($urandom_range(0, 399) == 0) do_async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
